// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end.
//   RX_W      : received frame width (2 command bits + 8 address/data bits)
//   TX_W      : read-data word width shifted out on MISO
//   state_e   : transaction FSM states
package spi_pkg;

    localparam int unsigned RX_W     = 10;
    localparam int unsigned TX_W     = 8;
    localparam int unsigned RX_CNT_W = $clog2(RX_W + 1);
    localparam int unsigned TX_CNT_W = $clog2(TX_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

endpackage

// File: rtl/spi_shift_rx.sv
// Serial-in shift register for one RX_W-bit MOSI frame, MSB first.
//   clk, rst_n : system clock, async active-low reset
//   clr        : clears the bit counter (between transactions)
//   en         : sample din this cycle
//   din        : serial data (MOSI)
//   rx_data    : last complete frame, held between frames
//   rx_valid   : one-cycle strobe in the cycle after the last bit is sampled
//   last       : the bit being sampled this cycle completes the frame
//   full       : a complete frame has been captured; further bits are ignored
module spi_shift_rx
    import spi_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            din,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    output logic            last,
    output logic            full
);

    // Only RX_W-1 bits need storing: the final bit goes straight into rx_data.
    logic [RX_W-2:0]     shift_q;
    logic [RX_CNT_W-1:0] cnt_q;
    logic [RX_W-1:0]     rx_data_q;
    logic                rx_valid_q;

    assign full     = (cnt_q == RX_CNT_W'(RX_W));
    assign last     = en && (cnt_q == RX_CNT_W'(RX_W - 1));
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= last;
            if (clr) begin
                cnt_q <= '0;
            end else if (en && !full) begin
                shift_q <= {shift_q[RX_W-3:0], din};
                cnt_q   <= cnt_q + RX_CNT_W'(1);
            end
            if (last) begin
                rx_data_q <= {shift_q, din};
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end between an SPI master and a RAM controller.
//   clk, rst_n : system clock, async active-low reset
//   MOSI, SS_n : serial data in and active-low select, sampled every rising edge
//   tx_data    : read data from RAM, qualified by tx_valid
//   MISO       : read data out, MSB first; 0 when not shifting
//   rx_data    : received frame, strobed by the one-cycle rx_valid
module spi_slave_if
    import spi_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MOSI,
    input  logic            SS_n,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid
);

    state_e              state_q, state_d;
    logic                rd_addr_done_q;
    logic [TX_W-1:0]     tx_shift_q;
    logic [TX_CNT_W-1:0] tx_cnt_q;
    logic                tx_busy_q;
    logic                tx_done_q;

    logic rx_en, rx_clr, rx_last, rx_full, in_data_state;

    assign in_data_state = (state_q == WRITE) || (state_q == READ_ADD) ||
                           (state_q == READ_DATA);
    assign rx_en  = in_data_state && !SS_n;
    assign rx_clr = SS_n || (state_q == IDLE);

    spi_shift_rx u_shift_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (rx_clr),
        .en       (rx_en),
        .din      (MOSI),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .last     (rx_last),
        .full     (rx_full)
    );

    // Combinational from reset-cleared flops, so reset forces MISO low at once.
    assign MISO = tx_busy_q & tx_shift_q[TX_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)          state_d = IDLE;
                else if (!MOSI)    state_d = WRITE;
                else if (rd_addr_done_q) state_d = READ_DATA;
                else               state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-data serialiser and address-phase flag. rd_addr_done survives an
    // abort so the master can retry the data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_done_q <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
        end else begin
            if ((state_q == READ_ADD) && rx_last) begin
                rd_addr_done_q <= 1'b1;
            end
            if (SS_n || (state_q != READ_DATA)) begin
                tx_busy_q <= 1'b0;
                tx_done_q <= 1'b0;
                tx_cnt_q  <= '0;
            end else if (tx_busy_q) begin
                if (tx_cnt_q == TX_CNT_W'(TX_W - 1)) begin
                    tx_busy_q      <= 1'b0;
                    tx_done_q      <= 1'b1;
                    rd_addr_done_q <= 1'b0;
                end else begin
                    tx_shift_q <= {tx_shift_q[TX_W-2:0], 1'b0};
                    tx_cnt_q   <= tx_cnt_q + TX_CNT_W'(1);
                end
            end else if (!tx_done_q && rx_full && tx_valid) begin
                tx_shift_q <= tx_data;
                tx_cnt_q   <= '0;
                tx_busy_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if with rx frame and MISO bit scoreboards.
module tb_spi_slave_if;
    import spi_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            MOSI;
    logic            SS_n;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;

    int total = 0;
    int bad   = 0;

    logic [RX_W-1:0] rx_q[$];
    logic            miso_q[$];
    bit              miso_go = 0;

    spi_slave_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MOSI     (MOSI),
        .SS_n     (SS_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; then score rx_valid/rx_data and MISO against the queues.
    task automatic tick();
        logic [RX_W-1:0] exp_f;
        logic            exp_b;
        @(posedge clk);
        #1;
        if (rx_valid === 1'b1 && rx_q.size() > 0) begin
            exp_f = rx_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(exp_f));
        end else begin
            check("rx_valid_idle", 32'(rx_valid), 32'(0));
        end
        if (miso_go && miso_q.size() > 0) begin
            exp_b = miso_q.pop_front();
            check("miso_bit", 32'(MISO), 32'(exp_b));
            if (miso_q.size() == 0) miso_go = 0;
        end else begin
            check("miso_quiet", 32'(MISO), 32'(0));
        end
    endtask

    task automatic deselect();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    // Command bit then the first nbits of frame f; full frames are expected back.
    task automatic send_frame(input logic cmd, input logic [RX_W-1:0] f, input int nbits);
        if (nbits == RX_W) rx_q.push_back(f);
        SS_n = 1'b0;
        tick();
        MOSI = cmd;
        tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI = f[RX_W-1-i];
            tick();
        end
        MOSI = 1'b0;
    endtask

    task automatic expect_miso(input logic [TX_W-1:0] w);
        for (int i = TX_W - 1; i >= 0; i--) miso_q.push_back(w[i]);
        miso_go = 1;
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b0; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;

        // Reset held with select active and MOSI toggling.
        for (int i = 0; i < 4; i++) begin
            MOSI = ~MOSI;
            tick();
        end
        check("reset_rx_data", 32'(rx_data), 32'(0));
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        check("reset_rd_addr_done", 32'(dut.rd_addr_done_q), 32'(0));
        rst_n = 1'b1;
        deselect();

        // Write frame.
        send_frame(1'b0, 10'b00_1010_0101, RX_W);
        tick();
        check("write_rx_seen", 32'(rx_q.size()), 32'(0));
        check("write_rx_hold", 32'(rx_data), 32'h0A5);
        deselect();
        check("write_idle", 32'(dut.state_q), 32'(IDLE));
        check("write_no_addr", 32'(dut.rd_addr_done_q), 32'(0));

        // Read address.
        send_frame(1'b1, 10'b10_0000_0011, RX_W);
        tick();
        check("rdaddr_rx_seen", 32'(rx_q.size()), 32'(0));
        check("rdaddr_done_set", 32'(dut.rd_addr_done_q), 32'(1));
        deselect();
        check("rdaddr_done_kept", 32'(dut.rd_addr_done_q), 32'(1));

        // Read data: frame, then RAM word serialised on MISO.
        send_frame(1'b1, 10'b11_0000_0000, RX_W);
        check("rddata_state", 32'(dut.state_q), 32'(READ_DATA));
        tick();
        tick();
        check("rddata_rx_seen", 32'(rx_q.size()), 32'(0));
        tx_data = 8'h0F; tx_valid = 1'b1;
        expect_miso(8'h0F);
        tick();
        tx_valid = 1'b0; tx_data = 8'hFF;
        for (int i = 0; i < TX_W - 1; i++) tick();
        check("rddata_miso_all", 32'(miso_q.size()), 32'(0));
        tick();
        check("rddata_done_clr", 32'(dut.rd_addr_done_q), 32'(0));
        tx_valid = 1'b1;
        tick();
        tick();
        tx_valid = 1'b0;
        deselect();

        // Abort a write after five bits, then a clean frame.
        send_frame(1'b0, 10'b11_1111_1111, 5);
        deselect();
        check("abort_idle", 32'(dut.state_q), 32'(IDLE));
        check("abort_rx_hold", 32'(rx_data), 32'h300);
        send_frame(1'b0, 10'h15A, RX_W);
        tick();
        check("after_abort_rx", 32'(rx_q.size()), 32'(0));
        deselect();

        // Read address, then read data interrupted by reset mid-shift.
        send_frame(1'b1, 10'h2AA, RX_W);
        deselect();
        send_frame(1'b1, 10'h3AA, RX_W);
        tick();
        tx_data = 8'hC3; tx_valid = 1'b1;
        expect_miso(8'hC3);
        tick();
        tx_valid = 1'b0;
        tick();
        check("midrst_miso_high", 32'(MISO), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_miso", 32'(MISO), 32'(0));
        check("midrst_addr_done", 32'(dut.rd_addr_done_q), 32'(0));
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        miso_q.delete();
        miso_go = 0;
        tick();
        rst_n = 1'b1;
        deselect();
        check("final_rx_queue", 32'(rx_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
